// File: rtl/jpeg_cone_pkg.sv
// ----------------------------------------------------------------------------
// jpeg_cone_pkg
//   Shared definitions for the cone scheduler slice.
//   OPW     : operand width of one requester (x[4:0]).
//   cone_f  : the NAND/NAND/NOR -> majority evaluation cone.
// ----------------------------------------------------------------------------
package jpeg_cone_pkg;

    localparam int OPW = 5;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // f(x) = MAJ(~(x0&x2), ~(x3&x0), ~(x4|x1))
    function automatic logic cone_f(input logic [OPW-1:0] x);
        logic nand_02;
        logic nand_30;
        logic nor_41;
        nand_02 = ~(x[0] & x[2]);
        nand_30 = ~(x[3] & x[0]);
        nor_41  = ~(x[4] | x[1]);
        return maj3(nand_02, nand_30, nor_41);
    endfunction

endpackage

// File: rtl/jpeg_cone_eval.sv
// ----------------------------------------------------------------------------
// jpeg_cone_eval
//   The single shared evaluation cone, purely combinational.
//   operand : 5-bit operand selected by the scheduler's grant mux.
//   result  : cone_f(operand).
// ----------------------------------------------------------------------------
module jpeg_cone_eval
    import jpeg_cone_pkg::*;
(
    input  logic [OPW-1:0] operand,
    output logic           result
);

    assign result = cone_f(operand);

endmodule

// File: rtl/jpeg_cone_scheduler.sv
// ----------------------------------------------------------------------------
// jpeg_cone_scheduler
//   Shares one evaluation cone among NREQ requesters with round-robin
//   arbitration and a registered result stage carrying the requester ID.
//
//   clk, rst    : rising-edge clock, asynchronous active-high reset.
//   req_valid   : per-requester operand valid.
//   req_data    : packed operands, requester i at [5i+4:5i].
//   req_ready   : one-hot grant, combinational from req_valid/rr_ptr/stall.
//   out_valid   : result register holds a result.
//   out_ready   : consumer accepts the result.
//   out_data    : cone result.
//   out_id      : requester that produced out_data.
//   eval_count  : total accepted evaluations, wrapping.
// ----------------------------------------------------------------------------
module jpeg_cone_scheduler
    import jpeg_cone_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*OPW-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_data,
    output logic [IDW-1:0]      out_id,
    output logic [CNTW-1:0]     eval_count
);

    logic [IDW-1:0]  rr_ptr;
    logic [NREQ-1:0] rot_valid;
    logic [IDW-1:0]  grant_off;
    logic [IDW-1:0]  grant_idx;
    logic            grant_any;
    logic            stall;
    logic            fire;
    logic [OPW-1:0]  grant_x;
    logic            grant_f;

    // (base + off) mod NREQ without a divider; off is always < NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    assign stall = out_valid & ~out_ready;

    // Rotate so rr_ptr sits at position 0, find the first set bit, then
    // rotate the offset back into an absolute requester index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        rot_valid = '0;
        grant_off = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            rot_valid[k] = req_valid[wrap_add(rr_ptr, k)];
        end
        // Descending scan: the last hit written is the lowest offset.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                grant_off = k[IDW-1:0];
                grant_any = 1'b1;
            end
        end
    end

    assign grant_idx = wrap_add(rr_ptr, int'(grant_off));
    assign fire      = grant_any & ~stall;

    always_comb begin
        req_ready = '0;
        if (fire) req_ready[grant_idx] = 1'b1;
    end

    assign grant_x = req_data[OPW*int'(grant_idx) +: OPW];

    jpeg_cone_eval u_eval (
        .operand (grant_x),
        .result  (grant_f)
    );

    // A grant replaces the register contents even while the old result is
    // drained in the same cycle, which gives full throughput.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= 1'b0;
            out_id     <= '0;
            rr_ptr     <= '0;
            eval_count <= '0;
        end else if (fire) begin
            out_valid  <= 1'b1;
            out_data   <= grant_f;
            out_id     <= grant_idx;
            rr_ptr     <= wrap_add(grant_idx, 1);
            eval_count <= eval_count + 1'b1;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/jpeg_cone_scheduler.md
# jpeg_cone_scheduler

Shares one combinational evaluation cone (the NAND/NAND/NOR→majority timing cone) among NREQ requesters. Fair round-robin arbitration, a registered result stage with requester ID, and valid/ready backpressure on both sides. Sits between the requester-side control logic and the consumer of cone results. One operand vector is accepted per cycle when the output is not stalled.

## Interface
- NREQ, 4: number of requesters (2..8).
- IDW, $clog2(NREQ): width of requester ID.
- CNTW, 16: width of the evaluation counter.
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  NREQ  per-requester operand valid.
- req_data  input  NREQ*5  packed operands; requester i uses bits [5i+4:5i] as x[4:0].
- req_ready  output  NREQ  one-hot grant; handshake completes where valid&ready.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  1  cone result.
- out_id  output  IDW  requester that produced out_data.
- eval_count  output  CNTW  total accepted evaluations, wraps.

## Operation
- Cone function: f(x) = MAJ(~(x0&x2), ~(x3&x0), ~(x4|x1)).
- Stall condition: stall = out_valid & ~out_ready.
- Grant rule: when ~stall, assert req_ready[i] for the first i with req_valid[i] set. The search starts at rr_ptr and wraps modulo NREQ. At most one bit of req_ready is set.
- When stall is asserted, or no request is valid, req_ready = 0.
- req_ready is combinational from req_valid, rr_ptr and stall. It does not depend on req_data.
- On a grant to i:
  - out_data <= f(req_data[i]);
  - out_id <= i;
  - out_valid <= 1;
  - rr_ptr <= (i+1) mod NREQ;
  - eval_count <= eval_count+1 (wraps from all-ones to 0).
- No grant and out_ready=1: out_valid <= 0. out_data and out_id hold their values.
- No grant and stall: all registers hold.
- A grant and a drain in the same cycle is legal. The new result replaces the drained one, giving full throughput.
- rr_ptr advances only on a grant.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_id=0, eval_count=0.
  - rr_ptr=0; therefore req_ready=0 while no request is valid.
- Latency: request accepted in cycle t; the result is visible on out_* in cycle t+1.
- Throughput: 1 evaluation/cycle with out_ready held high.
- Backpressure: while stalled, out_data, out_id and out_valid are stable and req_ready is 0.
- Requesters may drop req_valid without a handshake. No state is kept per requester.
- Reset mid-operation: the pending result is discarded, the pointer returns to 0 and the count is cleared. The first grant after reset follows the normal rule with rr_ptr=0.
- Simultaneous requests: only one is granted per cycle. A persistently valid requester waits at most NREQ-1 grants.

## Structure
- Shared package jpeg_cone_pkg holds:
  - the constant OPW=5;
  - the function cone_f(x[4:0]) implementing the MAJ/NAND/NOR expression.
- Sub-module jpeg_cone_eval: purely combinational, 5-bit operand in, 1-bit result out. It is instantiated once and fed by the granted operand mux.
- The top level contains:
  - the round-robin priority search, implemented as a rotate, find-first, rotate back;
  - the operand mux;
  - the result register, pointer register and counter.

## Test plan
- Reset and single request: after reset, drive req_valid=4'b0001 with x=5'b00000 and out_ready=1. Required: req_ready=4'b0001 in that cycle; next cycle out_valid=1, out_data=1, out_id=0, eval_count=1.
- Function check, requester 2: x=5'b01101 gives out_data=0; x=5'b00101 gives out_data=1; x=5'b11111 gives out_data=0. Each appears with out_id=2.
- Fairness: all four requesters valid continuously with out_ready=1. Required grant order 0,1,2,3,0,1, one per cycle, eval_count incrementing by 1 each cycle.
- Backpressure: after one result, hold out_ready=0 for 3 cycles with all requesters valid. Required:
  - req_ready=0 and out_* stable for those 3 cycles;
  - on the cycle out_ready returns to 1, the next requester in rotation is granted and its result appears one cycle later.
- Counter wrap: preload via 2^CNTW-1 grants, or use CNTW=4 with 15 grants. One more grant brings eval_count to 0.
- Async reset mid-stall: assert rst while out_valid=1 and out_ready=0. Required: out_valid=0, eval_count=0 and rr_ptr=0 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest valid index.
